// File: rtl/reg_pkg.sv
// Shared register-file definitions used by the writeback path.
//   ADDR_W     : register address width
//   BUS_W      : register data width
//   REG_ZERO   : hard-wired zero register; writes to it are discarded
//   wb_entry_t : one pending writeback {addr, data, valid}
package reg_pkg;

    localparam int ADDR_W = 5;
    localparam int BUS_W  = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BUS_W-1:0]  data;
        logic              valid;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Forwarding lookup over the writeback FIFO contents.
// Finds the youngest pending entry whose address equals lookup_addr.
//   entry_addr/entry_data/entry_valid : FIFO storage, indexed by slot
//   head      : slot of the oldest pending entry
//   count     : number of pending entries
//   lookup_addr : register being read
//   hit       : a pending entry matches (never for register zero)
//   data      : youngest matching value, 0 on miss
module wb_fwd_match #(
    parameter int ADDR  = 5,
    parameter int BUS_W = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][ADDR-1:0]  entry_addr,
    input  logic [DEPTH-1:0][BUS_W-1:0] entry_data,
    input  logic [DEPTH-1:0]            entry_valid,
    input  logic [PTR_W-1:0]            head,
    input  logic [CNT_W-1:0]            count,
    input  logic [ADDR-1:0]             lookup_addr,
    output logic                        hit,
    output logic [BUS_W-1:0]            data
);

    logic [PTR_W-1:0] idx;

    // Walk from the youngest occupied offset (count-1, next to the tail)
    // back toward the head; the first match found is the youngest one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = head + PTR_W'(k);
            if (!hit && (CNT_W'(k) < count) && entry_valid[idx] &&
                (entry_addr[idx] == lookup_addr) && (lookup_addr != '0)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/wb_buffer.sv
// Writeback buffer in front of the register file write port.
// Queues execute results in a DEPTH-entry FIFO, drains one per enabled
// cycle, and forwards pending values to the rs/rt read ports.
//   reloj_cucu, reset        : clock (rising edge), async active-high reset
//   in_valid/in_ready        : result handshake from execute
//   in_rd_addr/in_data       : result destination and value
//   drain_en                 : register file write port free this cycle
//   r_write/rd_addr/rd_w_data: register file write port
//   rs_addr/rt_addr          : operand addresses being read
//   rs_fwd_*/rt_fwd_*        : forwarding hit and youngest pending value
//   occupancy                : pending entry count
module wb_buffer #(
    parameter int ADDR  = 5,
    parameter int BUS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                         reloj_cucu,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR-1:0]              in_rd_addr,
    input  logic [BUS_W-1:0]             in_data,
    input  logic                         drain_en,
    output logic                         r_write,
    output logic [ADDR-1:0]              rd_addr,
    output logic [BUS_W-1:0]             rd_w_data,
    input  logic [ADDR-1:0]              rs_addr,
    input  logic [ADDR-1:0]              rt_addr,
    output logic                         rs_fwd_hit,
    output logic [BUS_W-1:0]             rs_fwd_data,
    output logic                         rt_fwd_hit,
    output logic [BUS_W-1:0]             rt_fwd_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    import reg_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;

    logic [DEPTH-1:0][ADDR-1:0]  addr_vec;
    logic [DEPTH-1:0][BUS_W-1:0] data_vec;
    logic [DEPTH-1:0]            valid_vec;

    logic not_empty;
    logic push_fire;
    logic do_push;
    logic do_pop;

    assign not_empty = (count_reg != '0);
    // Full blocks a push even when a pop happens in the same cycle, so
    // in_ready depends only on registered state and reset.
    assign in_ready  = (count_reg != CNT_W'(DEPTH)) && !reset;
    assign push_fire = in_valid && in_ready;
    // Results for the zero register finish the handshake but are dropped.
    assign do_push   = push_fire && (in_rd_addr != ADDR'(REG_ZERO));
    assign do_pop    = r_write;

    assign r_write   = drain_en && not_empty;
    assign rd_addr   = not_empty ? addr_vec[head_reg] : '0;
    assign rd_w_data = not_empty ? data_vec[head_reg] : '0;
    assign occupancy = count_reg;

    // Per-slot storage. A slot is written only at the tail and cleared
    // only at the head; both coincide only when empty or full, where one
    // of the two operations cannot happen.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [ADDR-1:0]  addr_reg;
        logic [BUS_W-1:0] data_reg;
        logic             valid_reg;

        always_ff @(posedge reloj_cucu or posedge reset) begin
            if (reset) begin
                addr_reg  <= '0;
                data_reg  <= '0;
                valid_reg <= 1'b0;
            end else if (do_push && (tail_reg == PTR_W'(gi))) begin
                addr_reg  <= in_rd_addr;
                data_reg  <= in_data;
                valid_reg <= 1'b1;
            end else if (do_pop && (head_reg == PTR_W'(gi))) begin
                valid_reg <= 1'b0;
            end
        end

        assign addr_vec[gi]  = addr_reg;
        assign data_vec[gi]  = data_reg;
        assign valid_vec[gi] = valid_reg;
    end

    always_ff @(posedge reloj_cucu or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (do_pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    wb_fwd_match #(
        .ADDR  (ADDR),
        .BUS_W (BUS_W),
        .DEPTH (DEPTH)
    ) u_rs_match (
        .entry_addr  (addr_vec),
        .entry_data  (data_vec),
        .entry_valid (valid_vec),
        .head        (head_reg),
        .count       (count_reg),
        .lookup_addr (rs_addr),
        .hit         (rs_fwd_hit),
        .data        (rs_fwd_data)
    );

    wb_fwd_match #(
        .ADDR  (ADDR),
        .BUS_W (BUS_W),
        .DEPTH (DEPTH)
    ) u_rt_match (
        .entry_addr  (addr_vec),
        .entry_data  (data_vec),
        .entry_valid (valid_vec),
        .head        (head_reg),
        .count       (count_reg),
        .lookup_addr (rt_addr),
        .hit         (rt_fwd_hit),
        .data        (rt_fwd_data)
    );

endmodule
